// File: rtl/disp_scan.sv
// Three-digit multiplexed display scanner: a prescaler steps the digit index,
// and a loaded value is held pending until the frame wraps so that a frame is never torn.
module disp_scan #(
    parameter int PRESCALE = 50000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Load,
    input  logic [9:0] Data,
    input  logic       Blank,
    output logic [3:0] D,
    output logic [2:0] DigitSel,
    output logic       Pending,
    output logic       FrameTick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

    localparam logic [1:0] IDX0 = 2'd0;
    localparam logic [1:0] IDX1 = 2'd1;
    localparam logic [1:0] IDX2 = 2'd2;

    logic [CW-1:0] cnt_reg;
    logic [1:0]    idx_reg;
    logic [1:0]    idx_next;
    logic [9:0]    disp_reg;
    logic [9:0]    pend_reg;
    logic          pending_reg;
    logic          frame_reg;
    logic          tick;
    logic          wrap;

    assign tick = (cnt_reg == CNT_LAST);
    assign wrap = tick && (idx_reg == IDX2);

    always_comb begin
        idx_next = idx_reg;
        if (tick) begin
            case (idx_reg)
                IDX0:    idx_next = IDX1;
                IDX1:    idx_next = IDX2;
                default: idx_next = IDX0;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_reg <= '0;
            idx_reg <= IDX0;
        end else begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
            idx_reg <= idx_next;
        end
    end

    // A Load on the wrap edge still commits the previous pending value;
    // the new value stays pending for the following frame.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            disp_reg    <= '0;
            pend_reg    <= '0;
            pending_reg <= 1'b0;
            frame_reg   <= 1'b0;
        end else begin
            frame_reg <= wrap;
            if (wrap && pending_reg) begin
                disp_reg <= pend_reg;
            end
            if (Load) begin
                pend_reg    <= Data;
                pending_reg <= 1'b1;
            end else if (wrap) begin
                pending_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        D = 4'h0;
        case (idx_reg)
            IDX0:    D = disp_reg[3:0];
            IDX1:    D = disp_reg[7:4];
            IDX2:    D = {2'b00, disp_reg[9:8]};
            default: D = 4'h0;
        endcase
    end

    // Blank only masks the enables; scanning keeps running underneath.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sel
            assign DigitSel[gi] = Blank | (idx_reg != 2'(gi));
        end
    endgenerate

    assign Pending   = pending_reg;
    assign FrameTick = frame_reg;

endmodule

// File: tb/tb_disp_scan.sv
// Directed scenarios for disp_scan at PRESCALE=4; expectations are queued per cycle
// and a monitor compares them against the outputs as the cycle counter reaches them.
module tb_disp_scan;

    logic       Clock;
    logic       Resetn;
    logic       Load;
    logic [9:0] Data;
    logic       Blank;
    logic [3:0] D;
    logic [2:0] DigitSel;
    logic       Pending;
    logic       FrameTick;

    disp_scan #(.PRESCALE(4)) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .Load(Load),
        .Data(Data),
        .Blank(Blank),
        .D(D),
        .DigitSel(DigitSel),
        .Pending(Pending),
        .FrameTick(FrameTick)
    );

    typedef struct {
        int         scn;
        int         cyc;
        logic [3:0] d;
        logic [2:0] sel;
        logic       pend;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   scn   = 0;
    int   cyc   = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Cycle number relative to the latest reset release.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Monitor: key -1 means "while reset is asserted".
    always begin
        int   key;
        exp_t e;
        @(negedge Clock);
        #1;
        key = Resetn ? cyc : -1;
        if (exp_q.size() > 0 && exp_q[0].cyc == key) begin
            e = exp_q.pop_front();
            n_vec++;
            if (D !== e.d || DigitSel !== e.sel || Pending !== e.pend || FrameTick !== e.ft) begin
                n_err++;
                $display("FAIL s%0d_c%0d: got D=%h sel=%b pend=%b ft=%b, expected D=%h sel=%b pend=%b ft=%b",
                         e.scn, e.cyc, D, DigitSel, Pending, FrameTick, e.d, e.sel, e.pend, e.ft);
            end else begin
                $display("ok   s%0d_c%0d: D=%h sel=%b pend=%b ft=%b",
                         e.scn, e.cyc, D, DigitSel, Pending, FrameTick);
            end
        end
    end

    task automatic ex(input int c, input logic [3:0] d, input logic [2:0] sel,
                      input logic pend, input logic ft);
        exp_t e;
        e.scn = scn; e.cyc = c; e.d = d; e.sel = sel; e.pend = pend; e.ft = ft;
        exp_q.push_back(e);
    endtask

    task automatic at_cycle(input int n);
        int k;
        k = 0;
        while (cyc != n && k < 200) begin
            @(negedge Clock);
            k++;
        end
        if (cyc != n) begin
            n_err++;
            $display("FAIL s%0d_wait: reached cycle %0d, expected cycle %0d", scn, cyc, n);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Resetn = 1'b0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 300) begin
            @(negedge Clock);
            k++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL s%0d_drain: %0d checks left, expected 0", scn, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        Resetn = 1'b1;
        Load   = 1'b0;
        Data   = '0;
        Blank  = 1'b0;

        // 1: idle scan after reset, single FrameTick after cycle 11
        scn = 1;
        ex(-1, 4'h0, 3'b110, 0, 0);
        ex(0,  4'h0, 3'b110, 0, 0); ex(3,  4'h0, 3'b110, 0, 0);
        ex(4,  4'h0, 3'b101, 0, 0); ex(7,  4'h0, 3'b101, 0, 0);
        ex(8,  4'h0, 3'b011, 0, 0); ex(11, 4'h0, 3'b011, 0, 0);
        ex(12, 4'h0, 3'b110, 0, 1); ex(13, 4'h0, 3'b110, 0, 0);
        do_reset();
        drain();

        // 2: load 2A7 at cycle 2, shown from the next frame
        scn = 2;
        ex(-1, 4'h0, 3'b110, 0, 0);
        ex(2,  4'h0, 3'b110, 0, 0); ex(3,  4'h0, 3'b110, 1, 0);
        ex(7,  4'h0, 3'b101, 1, 0); ex(11, 4'h0, 3'b011, 1, 0);
        ex(12, 4'h7, 3'b110, 0, 1); ex(15, 4'h7, 3'b110, 0, 0);
        ex(16, 4'hA, 3'b101, 0, 0); ex(20, 4'h2, 3'b011, 0, 0);
        ex(24, 4'h7, 3'b110, 0, 1);
        do_reset();
        at_cycle(2); Load = 1'b1; Data = 10'h2A7;
        at_cycle(3); Load = 1'b0;
        drain();

        // 3: two loads before a commit, the last wins
        scn = 3;
        ex(-1, 4'h0, 3'b110, 0, 0);
        ex(2,  4'h0, 3'b110, 1, 0); ex(6,  4'h0, 3'b101, 1, 0);
        ex(12, 4'hF, 3'b110, 0, 1); ex(16, 4'hF, 3'b101, 0, 0);
        ex(20, 4'h3, 3'b011, 0, 0);
        do_reset();
        at_cycle(1); Load = 1'b1; Data = 10'h111;
        at_cycle(2); Load = 1'b0;
        at_cycle(5); Load = 1'b1; Data = 10'h3FF;
        at_cycle(6); Load = 1'b0;
        drain();

        // 4: load coincident with the commit edge
        scn = 4;
        ex(-1, 4'h0, 3'b110, 0, 0);
        ex(11, 4'h0, 3'b011, 1, 0);
        ex(12, 4'hB, 3'b110, 1, 1); ex(16, 4'hA, 3'b101, 1, 0);
        ex(20, 4'h0, 3'b011, 1, 0);
        ex(24, 4'h5, 3'b110, 0, 1); ex(28, 4'h5, 3'b101, 0, 0);
        ex(32, 4'h1, 3'b011, 0, 0);
        do_reset();
        at_cycle(1);  Load = 1'b1; Data = 10'h0AB;
        at_cycle(2);  Load = 1'b0;
        at_cycle(11); Load = 1'b1; Data = 10'h155;
        at_cycle(12); Load = 1'b0;
        drain();

        // 5: blank a whole committed frame
        scn = 5;
        ex(-1, 4'h0, 3'b110, 0, 0);
        ex(0,  4'h0, 3'b110, 0, 0); ex(1,  4'h0, 3'b110, 1, 0);
        ex(12, 4'h7, 3'b111, 0, 1); ex(16, 4'hA, 3'b111, 0, 0);
        ex(23, 4'h2, 3'b111, 0, 0);
        ex(24, 4'h7, 3'b110, 0, 1); ex(28, 4'hA, 3'b101, 0, 0);
        do_reset();
        at_cycle(0);  Load = 1'b1; Data = 10'h2A7;
        at_cycle(1);  Load = 1'b0;
        at_cycle(12); Blank = 1'b1;
        at_cycle(24); Blank = 1'b0;
        drain();

        // 6: reset mid-frame with a value pending
        scn = 6;
        ex(-1, 4'h0, 3'b110, 0, 0);
        ex(2,  4'h0, 3'b110, 1, 0); ex(4,  4'h0, 3'b101, 1, 0);
        ex(-1, 4'h0, 3'b110, 0, 0);
        ex(0,  4'h0, 3'b110, 0, 0); ex(3,  4'h0, 3'b110, 0, 0);
        ex(4,  4'h0, 3'b101, 0, 0); ex(12, 4'h0, 3'b110, 0, 1);
        ex(16, 4'h0, 3'b101, 0, 0);
        do_reset();
        at_cycle(1); Load = 1'b1; Data = 10'h155;
        at_cycle(2); Load = 1'b0;
        at_cycle(5); Resetn = 1'b0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
